// File: rtl/mvm_pkg.sv
// Shared constants and FSM state type for the matrix-vector sequencer.
package mvm_pkg;
    localparam int LANES       = 8;
    localparam int DOT_LATENCY = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_CW     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
endpackage

// File: rtl/mvm_seq_if.sv
// Memory-read, dot-engine and result-stream signals of mvm_seq.
interface mvm_seq_if #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32,
    parameter int AWIDTH = 10
);
    logic [AWIDTH-1:0]                   mat_raddr;
    logic [mvm_pkg::LANES*IWIDTH-1:0]    mat_rdata;
    logic [AWIDTH-1:0]                   vec_raddr;
    logic [mvm_pkg::LANES*IWIDTH-1:0]    vec_rdata;
    logic [mvm_pkg::LANES*IWIDTH-1:0]    dot_vec0;
    logic [mvm_pkg::LANES*IWIDTH-1:0]    dot_vec1;
    logic                                dot_ivalid;
    logic [OWIDTH-1:0]                   dot_result;
    logic                                dot_ovalid;
    logic [OWIDTH-1:0]                   out_data;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output mat_raddr, vec_raddr, dot_vec0, dot_vec1, dot_ivalid, out_data, out_valid,
        input  mat_rdata, vec_rdata, dot_result, dot_ovalid, out_ready
    );
    modport slave (
        input  mat_raddr, vec_raddr, dot_vec0, dot_vec1, dot_ivalid, out_data, out_valid,
        output mat_rdata, vec_rdata, dot_result, dot_ovalid, out_ready
    );
endinterface

// File: rtl/mvm_res_fifo.sv
// Small result FIFO; push and pop in the same cycle are accepted even when full.
module mvm_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mvm_seq.sv
// Matrix-vector sequencer: streams chunk reads into an external 8-lane dot engine,
// accumulates per-row sums into a credit-guarded FIFO. Define MVM_SEQ_RELU_EN to clamp negative sums.
module mvm_seq
    import mvm_pkg::*;
#(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int CWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CWIDTH-1:0] num_rows,
    input  logic [CWIDTH-1:0] num_chunks,
    output logic              busy,
    output logic              done,
    mvm_seq_if.master         bus
);
    state_t state, state_nx;

    logic [CWIDTH-1:0]        rows_q, chunks_q, row_cnt, chunk_cnt, res_chunk;
    logic [AWIDTH-1:0]        addr_cnt;
    logic [FIFO_CW-1:0]       inflight, fifo_cnt;
    logic                     issue, row_first, last_chunk, last_row, credit_ok, res_last;
    logic                     ivalid_q, push, pop, fifo_empty;
    logic signed [OWIDTH-1:0] acc, acc_base, acc_sum, row_sum;
    logic [OWIDTH-1:0]        fifo_dout;

    assign row_first  = (chunk_cnt == '0);
    assign last_chunk = (chunk_cnt == chunks_q - CWIDTH'(1));
    assign last_row   = (row_cnt == rows_q - CWIDTH'(1));
    // Rows already reserved downstream (in the engine or sitting in the FIFO) must leave a free slot.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (FIFO_CW + 1)'(FIFO_DEPTH);
    assign issue      = (state == ISSUE) && (!row_first || credit_ok);
    assign res_last   = (res_chunk == chunks_q - CWIDTH'(1));
    assign push       = bus.dot_ovalid && res_last;

    always_comb begin
        acc_base = (res_chunk == '0) ? '0 : acc;
        acc_sum  = acc_base + $signed(bus.dot_result);
`ifdef MVM_SEQ_RELU_EN
        row_sum  = acc_sum[OWIDTH-1] ? '0 : acc_sum;
`else
        row_sum  = acc_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == FIN);
        case (state)
            IDLE:    if (start) state_nx = (num_rows != '0) ? ISSUE : FIN;
            ISSUE:   if (issue && last_chunk && last_row) state_nx = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_empty) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q    <= '0;
            chunks_q  <= '0;
            row_cnt   <= '0;
            chunk_cnt <= '0;
            addr_cnt  <= '0;
            res_chunk <= '0;
            inflight  <= '0;
            ivalid_q  <= 1'b0;
            acc       <= '0;
        end else begin
            if (state == IDLE && start) begin
                rows_q    <= num_rows;
                chunks_q  <= num_chunks;
                row_cnt   <= '0;
                chunk_cnt <= '0;
                addr_cnt  <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + AWIDTH'(1);
                if (last_chunk) begin
                    chunk_cnt <= '0;
                    row_cnt   <= row_cnt + CWIDTH'(1);
                end else begin
                    chunk_cnt <= chunk_cnt + CWIDTH'(1);
                end
            end
            ivalid_q <= issue;
            case ({issue && row_first, push})
                2'b10:   inflight <= inflight + FIFO_CW'(1);
                2'b01:   inflight <= inflight - FIFO_CW'(1);
                default: ;
            endcase
            if (bus.dot_ovalid) begin
                acc       <= acc_sum;
                res_chunk <= res_last ? '0 : res_chunk + CWIDTH'(1);
            end
        end
    end

    assign bus.mat_raddr  = addr_cnt;
    assign bus.vec_raddr  = AWIDTH'(chunk_cnt);
    assign bus.dot_vec0   = bus.mat_rdata;
    assign bus.dot_vec1   = bus.vec_rdata;
    assign bus.dot_ivalid = ivalid_q;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_dout;
    assign pop            = bus.out_valid && bus.out_ready;

    mvm_res_fifo #(
        .WIDTH (OWIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (FIFO_CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (row_sum),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );
endmodule

// File: tb/tb_mvm_seq.sv
// Bench for mvm_seq: memory + 4-cycle dot engine models, row sums from a plain arithmetic model.
module tb_mvm_seq;
    import mvm_pkg::*;

    localparam int IW = 8, OW = 32, AW = 10, CW = 6;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [CW-1:0] num_rows = '0, num_chunks = CW'(1);
    logic          busy, done;

    mvm_seq_if #(.IWIDTH(IW), .OWIDTH(OW), .AWIDTH(AW)) bus ();

    mvm_seq #(.IWIDTH(IW), .OWIDTH(OW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .num_chunks(num_chunks), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [LANES*IW-1:0] mat_mem [1024];
    logic [LANES*IW-1:0] vec_mem [1024];

    always @(posedge clk) begin
        bus.mat_rdata <= mat_mem[bus.mat_raddr];
        bus.vec_rdata <= vec_mem[bus.vec_raddr];
    end

    function automatic int elem(input logic [LANES*IW-1:0] w, input int l);
        logic signed [IW-1:0] e;
        e = w[l*IW +: IW];
        return int'(e);
    endfunction

    function automatic int dot8(input logic [LANES*IW-1:0] a, input logic [LANES*IW-1:0] b);
        int s = 0;
        for (int l = 0; l < LANES; l++) s += elem(a, l) * elem(b, l);
        return s;
    endfunction

    // Dot engine: fixed latency, cleared by the shared reset
    logic [DOT_LATENCY:1]  evld;
    logic signed [OW-1:0]  eres [DOT_LATENCY:1];
    always @(posedge clk) begin
        if (rst) evld <= '0;
        else     evld <= {evld[DOT_LATENCY-1:1], bus.dot_ivalid};
        eres[1] <= dot8(bus.dot_vec0, bus.dot_vec1);
        for (int k = 2; k <= DOT_LATENCY; k++) eres[k] <= eres[k-1];
    end
    assign bus.dot_ovalid = evld[DOT_LATENCY];
    assign bus.dot_result = eres[DOT_LATENCY];

    function automatic longint ref_row(input int r, input int c_n);
        longint s = 0;
        logic signed [OW-1:0] w;
        for (int c = 0; c < c_n; c++)
            for (int l = 0; l < LANES; l++)
                s += longint'(elem(mat_mem[r*c_n + c], l)) * longint'(elem(vec_mem[c], l));
        w = s[OW-1:0];
`ifdef MVM_SEQ_RELU_EN
        if (w < 0) w = '0;
`endif
        return longint'(w);
    endfunction

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    longint        got_q[$];
    int            iv_cnt = 0, cyc = 0, last_xfer = 0;
    bit            rdy_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) bus.out_ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: collects transfers, checks data holds while stalled
    initial begin : mon
        bit            hold_pend = 1'b0;
        logic [OW-1:0] hold_val = '0;
        forever begin
            @(negedge clk);
            if (rst) hold_pend = 1'b0;
            else begin
                if (hold_pend) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, hold_val);
                end
                if (bus.out_valid && bus.out_ready) begin
                    got_q.push_back(longint'($signed(bus.out_data)));
                    last_xfer = cyc;
                end
                if (bus.dot_ivalid) iv_cnt++;
                hold_pend = bus.out_valid && !bus.out_ready;
                hold_val  = bus.out_data;
            end
        end
    end

    task automatic fill(input bit rnd, input int mv, input int vv);
        for (int i = 0; i < 64; i++)
            for (int l = 0; l < LANES; l++) begin
                mat_mem[i][l*IW +: IW] = rnd ? IW'($urandom) : IW'(mv);
                vec_mem[i][l*IW +: IW] = rnd ? IW'($urandom) : IW'(vv);
            end
    endtask

    task automatic pulse_start(input int r_n, input int c_n);
        @(posedge clk); #1;
        start = 1'b1; num_rows = CW'(r_n); num_chunks = CW'(c_n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int r_n, input int c_n, input int hold, input bit poke);
        longint exp_q[$];
        bit     seen = 1'b0;
        int     done_cyc = 0;
        for (int r = 0; r < r_n; r++) exp_q.push_back(ref_row(r, c_n));
        got_q.delete();
        iv_cnt = 0;
        pulse_start(r_n, c_n);
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1; num_rows = CW'(7);
            @(posedge clk); #1;
            start = 1'b0; num_rows = CW'(r_n);
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            check("stall_issue", iv_cnt, ((r_n < 4) ? r_n : 4) * c_n);
            check("stall_busy", busy, 1);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        check("done_seen", seen, 1);
        check("done_lat", done_cyc - last_xfer, 2);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("n_out", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("row_sum", got_q[i], exp_q[i]);
        check("n_issue", iv_cnt, r_n * c_n);
        if (poke) begin
            repeat (3) @(negedge clk);
            check("poke_idle", busy, 0);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        fill(1'b1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oval", bus.out_valid, 0);
        check("rst_ival", bus.dot_ivalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        fill(1'b0, 1, 1);
        run_job(2, 1, 0, 1'b0);
        check("ones_r0", (got_q.size() > 0) ? got_q[0] : -1, 8);
        check("ones_r1", (got_q.size() > 1) ? got_q[1] : -1, 8);

        fill(1'b0, 2, -3);
        run_job(1, 3, 0, 1'b0);
`ifdef MVM_SEQ_RELU_EN
        check("neg_sum", (got_q.size() > 0) ? got_q[0] : -1, 0);
`else
        check("neg_sum", (got_q.size() > 0) ? got_q[0] : -1, -144);
`endif

        fill(1'b0, -128, -128);
        run_job(1, 2, 0, 1'b1);
        check("max_sum", (got_q.size() > 0) ? got_q[0] : -1, 262144);

        iv_cnt = 0;
        pulse_start(0, 1);
        @(negedge clk);
        check("zr_busy", busy, 1);
        check("zr_done", done, 1);
        @(negedge clk);
        check("zr_busy2", busy, 0);
        check("zr_done2", done, 0);
        check("zr_ival", iv_cnt, 0);

        fill(1'b1, 0, 0);
        bus.out_ready = 1'b0;
        run_job(8, 1, 20, 1'b0);

        bus.out_ready = 1'b1;
        pulse_start(4, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_oval", bus.out_valid, 0);
        check("ab_ival", bus.dot_ivalid, 0);
        run_job(4, 2, 0, 1'b0);

        rdy_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            fill(1'b1, 0, 0);
            run_job($urandom_range(1, 10), $urandom_range(1, 5), 0, 1'b0);
        end
        rdy_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mvm_seq.md
MVM_SEQ -- requirements
Module: mvm_seq

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, signed element width.
REQ-002 SHALL have parameter OWIDTH, default 32, signed result width.
REQ-003 SHALL have parameter AWIDTH, default 10, memory address width.
REQ-004 SHALL have parameter CWIDTH, default 6, width of the row and chunk count inputs.
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a job.
REQ-008 num_rows  input  CWIDTH  matrix rows; sampled on accepted start.
REQ-009 num_chunks  input  CWIDTH  8-element chunks per row, min 1; sampled on accepted start.
REQ-010 busy  output  1  high from the accepted start until done.
REQ-011 done  output  1  one-cycle pulse at job end.
REQ-012 mat_raddr  output  AWIDTH  matrix memory read address, row-major, one chunk per word.
REQ-013 mat_rdata  input  8*IWIDTH  matrix word; valid exactly 1 cycle after mat_raddr.
REQ-014 vec_raddr  output  AWIDTH  vector memory read address (chunk index).
REQ-015 vec_rdata  input  8*IWIDTH  vector word; valid 1 cycle after vec_raddr.
REQ-016 dot_vec0, dot_vec1  output  8*IWIDTH  operands to the 8-lane dot product engine.
REQ-017 dot_ivalid  output  1  operand valid to engine.
REQ-018 dot_result  input  OWIDTH  engine result.
REQ-019 dot_ovalid  input  1  engine result valid; fixed 4 cycles after dot_ivalid.
REQ-020 out_data  output  OWIDTH  row result stream.
REQ-021 out_valid  output  1  row result valid.
REQ-022 out_ready  input  1  consumer ready; transfer when out_valid and out_ready are both high.

Function
REQ-023 FSM SHALL have states IDLE, ISSUE, DRAIN, FIN.
- IDLE->ISSUE on start with num_rows>0.
- IDLE->FIN on start with num_rows=0.
- ISSUE->DRAIN after the last chunk of the last row is issued.
- DRAIN->FIN when no result is in flight and the FIFO is empty.
- FIN->IDLE unconditionally; done=1 in FIN only.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 ISSUE SHALL present one read per cycle: mat_raddr = row*num_chunks+chunk (running counter, no multiplier), vec_raddr = chunk, chunk-inner row-outer order.
REQ-026 dot_vec0/dot_vec1 SHALL be driven directly from mat_rdata/vec_rdata; dot_ivalid SHALL be the read-issue strobe delayed 1 cycle.
REQ-027 Accumulator SHALL sum dot_result over num_chunks consecutive dot_ovalid pulses, cleared at each row's first chunk, and wrap modulo 2^OWIDTH.
REQ-028 Each completed row sum SHALL be pushed into a 4-entry result FIFO feeding out_data/out_valid, in row order.
REQ-029 Credit rule: a row's first chunk SHALL issue only if (rows in flight + FIFO occupancy) < 4; otherwise issue stalls at the chunk boundary and no read is presented; mid-row chunks never stall.
REQ-030 Simultaneous FIFO push and pop SHALL be legal at any occupancy, including full.
REQ-031 The FIFO SHALL never overflow and SHALL never drop a result; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 Throughput with out_ready=1 SHALL be one chunk per cycle, with no bubbles between rows.

Reset
REQ-033 rst SHALL force state IDLE, busy=0, done=0, out_valid=0, dot_ivalid=0, all counters and the accumulator to 0, and the FIFO to empty.
REQ-034 rst mid-job SHALL abort the job; in-flight results SHALL be discarded. The engine shares the same rst.

Configuration
REQ-035 With MVM_SEQ_RELU_EN defined, each row sum SHALL be clamped to 0 if negative before the FIFO push; without it, the signed sum SHALL pass unchanged.

Structure
REQ-036 Package mvm_pkg SHALL hold LANES=8, DOT_LATENCY=4, FIFO_DEPTH=4, and the FSM state enum typedef.
REQ-037 The result FIFO SHALL be a sub-module named mvm_res_fifo (parameterised width/depth, count output).

Verification
REQ-038 num_rows=2, num_chunks=1, all elements 1, out_ready=1 -> outputs 8, 8; done one cycle after the FIFO empties.
REQ-039 num_rows=1, num_chunks=3, matrix=2, vector=-3 -> single output -144 (or 0 with MVM_SEQ_RELU_EN).
REQ-040 num_rows=8, num_chunks=1, out_ready=0 for 20 cycles -> exactly 4 rows issued, then issue stalls; after out_ready=1, all 8 results appear in order.
REQ-041 start with num_rows=0 -> busy high 1 cycle, done pulse, no dot_ivalid.
REQ-042 rst asserted 3 cycles into a num_rows=4 job -> all outputs at reset values the next cycle; a new start then produces correct results.
REQ-043 Elements -128 x -128, num_chunks=2 -> 262144; start pulsed while busy -> ignored.
